// File: rtl/mem_port_arbiter_if.sv
// Pipeline-facing and bus-facing signals of the IF/MEM memory port arbiter.
// slave is the arbiter's own view; master is the pipeline plus memory around it.
interface mem_port_arbiter_if;
  logic        flush;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [3:0]  d_err_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport slave (
    input  flush, i_req, i_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err, d_err_cause,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output flush, i_req, i_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err, d_err_cause,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store,
// data first, with a bounded streak guard so fetch cannot starve.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave port
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  state_e       state;
  owner_e       owner;
  logic [SW-1:0] streak;
  logic         kill;
  logic         lat_we;
  logic [1:0]   lat_off;
  logic [1:0]   lat_size;
  logic         lat_unsigned;

  logic         bus_req_q;
  logic         bus_we_q;
  logic [31:0]  bus_addr_q;
  logic [3:0]   bus_be_q;
  logic [31:0]  bus_wdata_q;
  logic         i_rvalid_q;
  logic [31:0]  i_rdata_q;
  logic         d_rvalid_q;
  logic [31:0]  d_rdata_q;
  logic         d_err_q;
  logic [3:0]   d_err_cause_q;

  logic         d_misaligned;
  logic         force_i;
  logic         pick_d;
  logic         pick_i;
  logic [3:0]   d_be;
  logic [31:0]  d_wdata_rep;
  logic [31:0]  load_shift;
  logic [31:0]  load_ext;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^port.i_addr[1:0];

  assign d_misaligned = ((port.d_size == 2'b01) && port.d_addr[0]) ||
                        (port.d_size[1] && (port.d_addr[1:0] != 2'b00));

  // Fetch jumps the queue only once data has won MAX_D_STREAK times in a row.
  assign force_i = port.i_req && !port.flush && (streak == STREAK_MAX);
  assign pick_d  = !rst && (state == IDLE) && port.d_req && !force_i;
  assign pick_i  = !rst && (state == IDLE) && port.i_req && !port.flush &&
                   (!port.d_req || force_i);

  assign port.d_gnt = pick_d;
  assign port.i_gnt = pick_i;

  always_comb begin
    d_be        = 4'b1111;
    d_wdata_rep = port.d_wdata;
    case (port.d_size)
      2'b00: begin
        d_be        = 4'b0001 << port.d_addr[1:0];
        d_wdata_rep = {4{port.d_wdata[7:0]}};
      end
      2'b01: begin
        d_be        = 4'b0011 << port.d_addr[1:0];
        d_wdata_rep = {2{port.d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign load_shift = port.bus_rdata >> {lat_off, 3'b000};

  always_comb begin
    load_ext = load_shift;
    case (lat_size)
      2'b00: load_ext = {{24{!lat_unsigned && load_shift[7]}}, load_shift[7:0]};
      2'b01: load_ext = {{16{!lat_unsigned && load_shift[15]}}, load_shift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      streak        <= '0;
      kill          <= 1'b0;
      lat_we        <= 1'b0;
      lat_off       <= 2'b00;
      lat_size      <= 2'b00;
      lat_unsigned  <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      i_rvalid_q    <= 1'b0;
      i_rdata_q     <= '0;
      d_rvalid_q    <= 1'b0;
      d_rdata_q     <= '0;
      d_err_q       <= 1'b0;
      d_err_cause_q <= '0;
    end else begin
      i_rvalid_q    <= 1'b0;
      d_rvalid_q    <= 1'b0;
      d_err_q       <= 1'b0;
      d_err_cause_q <= '0;

      if (!port.i_req || pick_i) begin
        streak <= '0;
      end else if (pick_d && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end

      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (pick_d) begin
            lat_we       <= port.d_we;
            lat_off      <= port.d_addr[1:0];
            lat_size     <= port.d_size;
            lat_unsigned <= port.d_unsigned;
            // Misaligned accesses never reach the bus; they are answered directly.
            if (d_misaligned) begin
              d_rvalid_q    <= 1'b1;
              d_err_q       <= 1'b1;
              d_err_cause_q <= port.d_we ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
              d_rdata_q     <= '0;
            end else begin
              owner       <= OWN_D;
              bus_req_q   <= 1'b1;
              bus_we_q    <= port.d_we;
              bus_addr_q  <= {port.d_addr[31:2], 2'b00};
              bus_be_q    <= d_be;
              bus_wdata_q <= d_wdata_rep;
              state       <= REQ;
            end
          end else if (pick_i) begin
            owner       <= OWN_I;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {port.i_addr[31:2], 2'b00};
            bus_be_q    <= 4'hF;
            bus_wdata_q <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (port.flush && (owner == OWN_I)) kill <= 1'b1;
          if (port.bus_gnt) begin
            bus_req_q <= 1'b0;
            state     <= RSP;
          end
        end
        RSP: begin
          if (port.flush && (owner == OWN_I)) kill <= 1'b1;
          if (port.bus_rvalid) begin
            state <= IDLE;
            owner <= OWN_NONE;
            kill  <= 1'b0;
            if (owner == OWN_D) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= lat_we ? 32'd0 : load_ext;
            end else if ((owner == OWN_I) && !kill && !port.flush) begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= port.bus_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign port.bus_req     = bus_req_q;
  assign port.bus_we      = bus_we_q;
  assign port.bus_addr    = bus_addr_q;
  assign port.bus_be      = bus_be_q;
  assign port.bus_wdata   = bus_wdata_q;
  assign port.i_rvalid    = i_rvalid_q;
  assign port.i_rdata     = i_rdata_q;
  assign port.d_rvalid    = d_rvalid_q;
  assign port.d_rdata     = d_rdata_q;
  assign port.d_err       = d_err_q;
  assign port.d_err_cause = d_err_cause_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a simple memory responder
// and an arithmetic reference model of lanes, extension, latency and arbitration.
module tb_mem_port_arbiter;
  localparam int MAX_D_STREAK = 4;

  logic clk = 1'b0;
  logic rst;
  mem_port_arbiter_if bif();

  mem_port_arbiter #(.MAX_D_STREAK(MAX_D_STREAK)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bif)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit          resp_on = 1'b1;
  bit          stray_pulse = 1'b0;
  int          gnt_delay = 0;
  int          rsp_delay = 0;
  logic [31:0] bus_word = '0;
  int          bus_seen = 0;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;

  // Memory model: grants after gnt_delay cycles, answers rsp_delay cycles later.
  initial begin
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_on) begin
        bif.bus_gnt = 1'b0;
        bif.bus_rvalid = stray_pulse;
        bif.bus_rdata = 32'hDEAD_BEEF;
      end else begin
        bif.bus_gnt = 1'b0;
        bif.bus_rvalid = 1'b0;
        if (bif.bus_req) begin
          bus_seen++;
          cap_we = bif.bus_we;
          cap_addr = bif.bus_addr;
          cap_wdata = bif.bus_wdata;
          cap_be = bif.bus_be;
          repeat (gnt_delay) @(negedge clk);
          bif.bus_gnt = 1'b1;
          @(negedge clk);
          bif.bus_gnt = 1'b0;
          repeat (rsp_delay) @(negedge clk);
          bif.bus_rvalid = 1'b1;
          bif.bus_rdata = bus_word;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic err, output logic [3:0] cause);
    int n;
    @(negedge clk);
    bif.d_req = 1'b1; bif.d_we = we; bif.d_addr = addr; bif.d_size = size;
    bif.d_unsigned = uns; bif.d_wdata = wdata;
    #1;
    n = 0;
    while (!bif.d_gnt && n < 50) begin @(negedge clk); #1; n++; end
    lat = -1; rdata = 'x; err = 'x; cause = 'x;
    if (!bif.d_gnt) begin bif.d_req = 1'b0; return; end
    @(negedge clk);
    bif.d_req = 1'b0;
    lat = 1;
    while (!bif.d_rvalid && lat < 60) begin @(negedge clk); lat++; end
    if (!bif.d_rvalid) lat = -1;
    rdata = bif.d_rdata; err = bif.d_err; cause = bif.d_err_cause;
  endtask

  task automatic do_fetch(input logic [31:0] addr, output int lat, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    bif.i_req = 1'b1; bif.i_addr = addr;
    #1;
    n = 0;
    while (!bif.i_gnt && n < 50) begin @(negedge clk); #1; n++; end
    lat = -1; rdata = 'x;
    if (!bif.i_gnt) begin bif.i_req = 1'b0; return; end
    @(negedge clk);
    bif.i_req = 1'b0;
    lat = 1;
    while (!bif.i_rvalid && lat < 60) begin @(negedge clk); lat++; end
    if (!bif.i_rvalid) lat = -1;
    rdata = bif.i_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; bif.flush = 1'b0;
    bif.i_req = 1'b1; bif.i_addr = 32'h0;
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h10; bif.d_size = 2'd2;
    bif.d_unsigned = 1'b0; bif.d_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (bif.bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bus_req: got %b want 0", bif.bus_req); end
    vectors++; if (bif.d_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_d_gnt: got %b want 0", bif.d_gnt); end
    vectors++; if (bif.i_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_i_gnt: got %b want 0", bif.i_gnt); end
    vectors++; if ({bif.d_rvalid, bif.i_rvalid, bif.d_err} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_valids: got %b want 000", {bif.d_rvalid, bif.i_rvalid, bif.d_err}); end
    vectors++; if ({bif.bus_be, bif.bus_addr} !== 36'h0) begin miscompares++; $display("[TB] FAIL reset_bus_fields: got %h want 0", {bif.bus_be, bif.bus_addr}); end
    bif.i_req = 1'b0; bif.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_byte();
    int lat; logic [31:0] rd; logic er; logic [3:0] ca;
    gnt_delay = 0; rsp_delay = 0; bus_word = 32'h80FF_FFFF;
    do_data(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, lat, rd, er, ca);
    vectors++; if (cap_be !== 4'b1000) begin miscompares++; $display("[TB] FAIL lb_be: got %b want 1000", cap_be); end
    vectors++; if (cap_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL lb_addr: got %h want 100", cap_addr); end
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL lb_latency: got %0d want 3", lat); end
    vectors++; if (rd !== 32'hFFFF_FF80) begin miscompares++; $display("[TB] FAIL lb_rdata: got %h want ffffff80", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_err: got %b want 0", er); end
  endtask

  task automatic test_store_half();
    int lat; logic [31:0] rd; logic er; logic [3:0] ca;
    gnt_delay = 0; rsp_delay = 0; bus_word = 32'h1234_5678;
    do_data(1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_ABCD, lat, rd, er, ca);
    vectors++; if (cap_be !== 4'b1100) begin miscompares++; $display("[TB] FAIL sh_be: got %b want 1100", cap_be); end
    vectors++; if (cap_wdata !== 32'hABCD_ABCD) begin miscompares++; $display("[TB] FAIL sh_wdata: got %h want abcdabcd", cap_wdata); end
    vectors++; if (cap_we !== 1'b1) begin miscompares++; $display("[TB] FAIL sh_we: got %b want 1", cap_we); end
    vectors++; if ({rd, er} !== 33'h0) begin miscompares++; $display("[TB] FAIL sh_resp: got rdata %h err %b want 0 0", rd, er); end
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL sh_latency: got %0d want 3", lat); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er; logic [3:0] ca; int seen0;
    seen0 = bus_seen;
    do_data(1'b0, 32'h6, 2'd2, 1'b0, 32'h0, lat, rd, er, ca);
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL mis_lw_latency: got %0d want 1", lat); end
    vectors++; if ({er, ca} !== 5'h14) begin miscompares++; $display("[TB] FAIL mis_lw_err: got err %b cause %0d want 1 4", er, ca); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL mis_lw_rdata: got %h want 0", rd); end
    do_data(1'b1, 32'h1, 2'd1, 1'b0, 32'h5555, lat, rd, er, ca);
    vectors++; if ({er, ca} !== 5'h16) begin miscompares++; $display("[TB] FAIL mis_sh_err: got err %b cause %0d want 1 6", er, ca); end
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL mis_sh_latency: got %0d want 1", lat); end
    vectors++; if (bus_seen !== seen0) begin miscompares++; $display("[TB] FAIL mis_no_bus: got %0d bus requests want 0", bus_seen - seen0); end
  endtask

  task automatic test_fetch();
    int lat; logic [31:0] rd; logic [31:0] addr;
    for (int k = 0; k < 6; k++) begin
      addr = $urandom; bus_word = $urandom;
      gnt_delay = $urandom_range(0, 2); rsp_delay = $urandom_range(0, 2);
      do_fetch(addr, lat, rd);
      vectors++; if (lat !== 3 + gnt_delay + rsp_delay) begin miscompares++; $display("[TB] FAIL fetch_latency[%0d]: got %0d want %0d", k, lat, 3 + gnt_delay + rsp_delay); end
      vectors++; if (rd !== bus_word) begin miscompares++; $display("[TB] FAIL fetch_rdata[%0d]: got %h want %h", k, rd, bus_word); end
      vectors++; if ({cap_be, cap_we} !== 5'b11110) begin miscompares++; $display("[TB] FAIL fetch_be_we[%0d]: got %b %b want 1111 0", k, cap_be, cap_we); end
      vectors++; if (cap_addr !== (addr & 32'hFFFF_FFFC)) begin miscompares++; $display("[TB] FAIL fetch_addr[%0d]: got %h want %h", k, cap_addr, addr & 32'hFFFF_FFFC); end
    end
  endtask

  task automatic test_random_data();
    int lat; logic [31:0] rd; logic er; logic [3:0] ca;
    logic we, uns; logic [1:0] size; logic [31:0] addr, wdata;
    int nb, off, seen0; bit mis;
    logic [31:0] val, mask, exp_wdata; logic [3:0] exp_be;
    for (int k = 0; k < 48; k++) begin
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom; bus_word = $urandom;
      gnt_delay = $urandom_range(0, 2); rsp_delay = $urandom_range(0, 2);
      nb = 1 << ((size == 2'd3) ? 2 : int'(size));
      off = int'(addr % 4);
      mis = (off % nb) != 0;
      seen0 = bus_seen;
      do_data(we, addr, size, uns, wdata, lat, rd, er, ca);
      if (mis) begin
        vectors++; if ({er, ca} !== {1'b1, (we ? 4'd6 : 4'd4)}) begin miscompares++; $display("[TB] FAIL rnd_mis_err[%0d]: got %b %0d want 1 %0d", k, er, ca, we ? 6 : 4); end
        vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL rnd_mis_latency[%0d]: got %0d want 1", k, lat); end
        vectors++; if (bus_seen !== seen0) begin miscompares++; $display("[TB] FAIL rnd_mis_bus[%0d]: got %0d want 0", k, bus_seen - seen0); end
      end else begin
        exp_be = 4'(((1 << nb) - 1) << off);
        for (int b = 0; b < 4; b++) exp_wdata[8*b +: 8] = wdata[8*(b % nb) +: 8];
        val = bus_word >> (8 * off);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        val = val & mask;
        if (!uns && nb < 4 && val >= (32'd1 << (8 * nb - 1))) val = val - (32'd1 << (8 * nb));
        if (we) val = 32'h0;
        vectors++; if (lat !== 3 + gnt_delay + rsp_delay) begin miscompares++; $display("[TB] FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, 3 + gnt_delay + rsp_delay); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_err[%0d]: got %b want 0", k, er); end
        vectors++; if (rd !== val) begin miscompares++; $display("[TB] FAIL rnd_rdata[%0d]: got %h want %h", k, rd, val); end
        vectors++; if (cap_be !== exp_be) begin miscompares++; $display("[TB] FAIL rnd_be[%0d]: got %b want %b", k, cap_be, exp_be); end
        vectors++; if (cap_addr !== addr - 32'(off)) begin miscompares++; $display("[TB] FAIL rnd_addr[%0d]: got %h want %h", k, cap_addr, addr - 32'(off)); end
        vectors++; if (cap_we !== we) begin miscompares++; $display("[TB] FAIL rnd_we[%0d]: got %b want %b", k, cap_we, we); end
        if (we) begin
          vectors++; if (cap_wdata !== exp_wdata) begin miscompares++; $display("[TB] FAIL rnd_wdata[%0d]: got %h want %h", k, cap_wdata, exp_wdata); end
        end
      end
    end
  endtask

  task automatic test_starvation();
    int got, cyc, exp_streak; bit exp_d;
    gnt_delay = 0; rsp_delay = 0; bus_word = 32'h0000_0013;
    @(negedge clk);
    bif.i_req = 1'b1; bif.i_addr = 32'h200;
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h10; bif.d_size = 2'd2; bif.d_unsigned = 1'b0;
    got = 0; cyc = 0; exp_streak = 0;
    while (got < 12 && cyc < 300) begin
      #1;
      if (bif.d_gnt || bif.i_gnt) begin
        exp_d = exp_streak < MAX_D_STREAK;
        vectors++;
        if (bif.d_gnt !== exp_d || bif.i_gnt !== !exp_d) begin
          miscompares++;
          $display("[TB] FAIL starve_grant[%0d]: got d %b i %b want d %b i %b", got, bif.d_gnt, bif.i_gnt, exp_d, !exp_d);
        end
        exp_streak = exp_d ? exp_streak + 1 : 0;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bif.i_req = 1'b0; bif.d_req = 1'b0;
    if (got < 12) begin
      vectors++; miscompares++;
      $display("[TB] FAIL starve_timeout: got %0d grants want 12", got);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_flush();
    int n; bit iv_seen;
    gnt_delay = 0; rsp_delay = 2; bus_word = 32'h0000_0013; iv_seen = 0;
    @(negedge clk);
    bif.i_req = 1'b1; bif.i_addr = 32'h300;
    #1;
    n = 0;
    while (!bif.i_gnt && n < 20) begin @(negedge clk); #1; n++; end
    vectors++; if (bif.i_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_fetch_gnt: got %b want 1", bif.i_gnt); end
    @(negedge clk); bif.i_req = 1'b0;
    @(negedge clk); bif.flush = 1'b1;
    @(negedge clk); bif.flush = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #2;
      if (bif.i_rvalid) iv_seen = 1;
      n++;
    end while (!bif.bus_rvalid && n < 20);
    vectors++; if (bif.bus_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_bus_rvalid: got %b want 1", bif.bus_rvalid); end
    bus_word = 32'hCAFE_F00D;
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h44; bif.d_size = 2'd2; bif.d_unsigned = 1'b0;
    bif.flush = 1'b1;
    #1;
    vectors++; if (bif.d_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_dgnt_in_rsp: got %b want 0", bif.d_gnt); end
    @(negedge clk); #1;
    if (bif.i_rvalid) iv_seen = 1;
    vectors++; if (bif.d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_dgnt_idle: got %b want 1", bif.d_gnt); end
    @(negedge clk);
    bif.d_req = 1'b0;
    n = 0;
    while (!bif.d_rvalid && n < 30) begin
      if (bif.i_rvalid) iv_seen = 1;
      @(negedge clk); n++;
    end
    vectors++; if ({bif.d_rvalid, bif.d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin miscompares++; $display("[TB] FAIL flush_data_rsp: got %b %h want 1 cafef00d", bif.d_rvalid, bif.d_rdata); end
    bif.flush = 1'b0;
    vectors++; if (iv_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_i_rvalid: got %b want 0", iv_seen); end
    rsp_delay = 0;
  endtask

  task automatic test_reset_in_req();
    int n; bit rv_seen;
    @(negedge clk); #2;
    resp_on = 1'b0;
    @(negedge clk);
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h80; bif.d_size = 2'd2; bif.d_unsigned = 1'b0;
    #1;
    n = 0;
    while (!bif.d_gnt && n < 20) begin @(negedge clk); #1; n++; end
    vectors++; if (bif.d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL rstreq_gnt: got %b want 1", bif.d_gnt); end
    @(negedge clk);
    bif.d_req = 1'b0;
    vectors++; if (bif.bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rstreq_bus_req_before: got %b want 1", bif.bus_req); end
    @(negedge clk);
    rst = 1'b1;
    #2 stray_pulse = 1'b1;
    @(negedge clk);
    vectors++; if (bif.bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rstreq_bus_req_after: got %b want 0", bif.bus_req); end
    rst = 1'b0;
    #2 stray_pulse = 1'b0;
    rv_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bif.d_rvalid || bif.i_rvalid) rv_seen = 1;
    end
    vectors++; if (rv_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL rstreq_stray_rvalid: got %b want 0", rv_seen); end
    vectors++; if (bif.bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rstreq_idle_bus_req: got %b want 0", bif.bus_req); end
    resp_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_fetch();
    test_random_data();
    test_starvation();
    test_flush();
    test_reset_in_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the rv32 pipeline.
- Fixed priority to data accesses, with a bounded starvation guard for fetch.
- Allows one outstanding bus transaction.
- Data side: generates byte enables, replicates write lanes, aligns load data and sign/zero-extends it, and flags misaligned accesses with rv32_pkg exception causes.

Parameters:
- MAX_D_STREAK, 4, max consecutive data grants while i_req is held before fetch is forced through (>=1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; kills fetch traffic
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  32  fetch address; bits [1:0] ignored
- i_gnt  out  1  fetch request accepted (combinational, IDLE only)
- i_rvalid  out  1  fetch data valid, one-cycle pulse
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request, held with fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte address
- d_size  in  2  mem_size_e: 0 = byte, 1 = half, 2 = word; 3 is treated as word
- d_unsigned  in  1  zero-extend load (funct3[2])
- d_wdata  in  32  store data, right-justified
- d_gnt  out  1  data request accepted (combinational, IDLE only)
- d_rvalid  out  1  data response pulse; also used for store ack and error
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  1  misaligned access, qualified by d_rvalid
- d_err_cause  out  4  exception_cause_e: 4 = load misaligned, 6 = store misaligned
- bus_req  out  1  bus request, held until bus_gnt
- bus_we  out  1  bus write
- bus_addr  out  32  word-aligned address {addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_gnt  in  1  bus accepted request
- bus_rvalid  in  1  bus response / write ack
- bus_rdata  in  32  bus read word

Behaviour:
- Reset: state IDLE, streak = 0, owner = none, kill = 0. All outputs 0.
  - Reset mid-transaction abandons it. Any later bus_rvalid is ignored because rvalid is honoured only in RSP.
- FSM states: IDLE, REQ, RSP.
- IDLE arbitration (per cycle):
  - Data is chosen if d_req, unless i_req && !flush && streak == MAX_D_STREAK, in which case fetch is chosen.
  - Otherwise fetch is chosen if i_req && !flush.
  - The chosen requester's gnt is asserted combinationally this cycle.
  - Request fields are latched and owner is recorded.
- IDLE next state:
  - If a data request is misaligned (half with addr[0]; word with addr[1:0] != 0), there is no bus transaction. The next cycle gives d_rvalid = 1, d_err = 1, d_err_cause = 6 if d_we else 4, d_rdata = 0. FSM stays IDLE.
  - Otherwise the next state is REQ.
- Streak counter:
  - On a data grant with i_req high: streak + 1, saturating.
  - On a fetch grant, or any cycle with i_req low: streak = 0.
- REQ: bus_req = 1 with latched bus_we/bus_addr/bus_be/bus_wdata held stable. On bus_gnt go to RSP. Unbounded wait.
- RSP: bus_req = 0. On bus_rvalid, register the response and go to IDLE.
  - The owner's rvalid pulses the next cycle, overlapping IDLE, so back-to-back arbitration is possible.
  - bus_rvalid in the same cycle as bus_gnt is not legal. bus_rvalid outside RSP is ignored.
- Latency: gnt at cycle t, bus_req from t+1. With bus_gnt at t+1 and bus_rvalid at t+2, the owner's rvalid is at t+3.
- Byte enables (off = addr[1:0]):
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- Write data: byte value replicated x4, half value replicated x2, word passed through.
- Load data: selected lane shifted to bit 0, then sign-extended or zero-extended (d_unsigned) to 32 bits. Store responses return d_rdata = 0, d_err = 0.
- Fetch: bus_be = 4'hF, bus_we = 0.
- Flush:
  - flush blocks a fetch grant in the same cycle.
  - If the owner is fetch in REQ or RSP, or flush coincides with the fetch grant in an earlier cycle's state, set kill. The transaction completes on the bus, but i_rvalid is suppressed. kill clears on return to IDLE.
  - Data transactions are unaffected by flush.
- Simultaneous d_req and i_req with streak < MAX: data wins. i_gnt = 0; i_req must stay high.

Test Plan:
1. Single load byte: d_addr = 0x103, d_size = 0, d_unsigned = 0, bus_rdata = 0x80FFFFFF, bus_gnt immediate, bus_rvalid next cycle -> bus_be = 4'b1000, bus_addr = 0x100, d_rvalid 3 cycles after d_gnt, d_rdata = 0xFFFFFF80.
2. Store half: d_addr = 0x22, d_wdata = 0x0000ABCD -> bus_be = 4'b1100, bus_wdata = 0xABCDABCD, bus_we = 1, d_rvalid with d_rdata = 0, d_err = 0.
3. Misaligned: word load at 0x6 -> no bus_req, d_rvalid next cycle, d_err = 1, d_err_cause = 4. Half store at 0x1 -> cause 6.
4. Starvation: i_req and d_req held continuously, MAX_D_STREAK = 4 -> grants D, D, D, D, I, D..., streak resets after the I grant.
5. Flush: fetch granted, flush pulsed during RSP, bus_rvalid with 0x00000013 -> i_rvalid never asserted; the following d_req is granted in the IDLE cycle.
6. Reset while in REQ: rst 1 cycle -> bus_req = 0 next cycle; a stray bus_rvalid afterwards produces no i_rvalid/d_rvalid.
